// File: rtl/clut_cache_filler_pkg.sv
// clut_cache_filler_pkg: shared CLUT$ fill constants, FSM state encoding and line geometry helper
package clut_cache_filler_pkg;

    localparam int CLUT_ADR_W      = 15;
    localparam int CLUT_LINE_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RECV = 3'd2,
        TAG  = 3'd3,
        DONE = 3'd4
    } fillState_t;

    function automatic int beatsFor(input int dataW);
        return CLUT_LINE_BYTES * 8 / dataW;
    endfunction

endpackage

// File: rtl/clut_cache_filler_if.sv
// clut_cache_filler_if: pipe-controller, VRAM-arbiter and CLUT$ RAM/tag signals of the filler
interface clut_cache_filler_if
    import clut_cache_filler_pkg::*;
#(
    parameter int SLOT_BITS = 4,
    parameter int DATA_W    = 32
);
    localparam int BEAT_BITS = $clog2(beatsFor(DATA_W));

    logic                             requClutCacheUpdate;
    logic [CLUT_ADR_W-1:0]            adrClutCacheUpdate;
    logic                             updateClutCacheComplete;
    logic                             o_busy;
    logic                             i_invalidate;
    logic                             o_memReq;
    logic [CLUT_ADR_W-1:0]            o_memAdr;
    logic                             i_memAck;
    logic                             i_memDataValid;
    logic [DATA_W-1:0]                i_memData;
    logic                             o_clutWrite;
    logic [SLOT_BITS-1:0]             o_clutWrSlot;
    logic [BEAT_BITS-1:0]             o_clutWrBeat;
    logic [DATA_W-1:0]                o_clutWrData;
    logic                             o_tagWrite;
    logic [CLUT_ADR_W-SLOT_BITS-1:0]  o_tagValue;
    logic                             o_tagValid;

    // filler side
    modport slave (
        input  requClutCacheUpdate, adrClutCacheUpdate, i_invalidate,
               i_memAck, i_memDataValid, i_memData,
        output updateClutCacheComplete, o_busy, o_memReq, o_memAdr,
               o_clutWrite, o_clutWrSlot, o_clutWrBeat, o_clutWrData,
               o_tagWrite, o_tagValue, o_tagValid
    );

    // pipeline / arbiter / cache side
    modport master (
        output requClutCacheUpdate, adrClutCacheUpdate, i_invalidate,
               i_memAck, i_memDataValid, i_memData,
        input  updateClutCacheComplete, o_busy, o_memReq, o_memAdr,
               o_clutWrite, o_clutWrSlot, o_clutWrBeat, o_clutWrData,
               o_tagWrite, o_tagValue, o_tagValid
    );

endinterface

// File: rtl/clut_fill_beat_counter.sv
// clut_fill_beat_counter: beat position within a CLUT$ line with clear, increment and last-beat flag
module clut_fill_beat_counter #(
    parameter int BEAT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 i_nrst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [BEAT_BITS-1:0] count,
    output logic                 last
);

    // beat count restarts at each accepted fetch and steps once per received beat
    always_ff @(posedge clk) begin
        if (!i_nrst || clear) count <= '0;
        else if (inc)         count <= count + 1'b1;
    end

    assign last = &count;

endmodule

// File: rtl/clut_cache_filler.sv
// clut_cache_filler: fetches a missed 32-byte CLUT$ line from VRAM, writes data and tag, pulses completion
module clut_cache_filler
    import clut_cache_filler_pkg::*;
#(
    parameter int SLOT_BITS = 4,
    parameter int DATA_W    = 32
) (
    input logic                  clk,
    input logic                  i_nrst,
    clut_cache_filler_if.slave   bus
);

    localparam int BEATS     = beatsFor(DATA_W);
    localparam int BEAT_BITS = $clog2(BEATS);

    fillState_t            state, nextState;
    logic [CLUT_ADR_W-1:0] adrReg;
    logic                  restart, nextRestart;
    logic                  cntClear, cntLast, beat;
    logic [BEAT_BITS-1:0]  cnt;

    assign beat = (state == RECV) && bus.i_memDataValid;

    clut_fill_beat_counter #(.BEAT_BITS(BEAT_BITS)) u_beatCounter (
        .clk   (clk),
        .i_nrst(i_nrst),
        .clear (cntClear),
        .inc   (beat),
        .count (cnt),
        .last  (cntLast)
    );

    // state, restart flag and the address captured only when a miss is accepted in IDLE
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            state   <= IDLE;
            adrReg  <= '0;
            restart <= 1'b0;
        end else begin
            state   <= nextState;
            restart <= nextRestart;
            if (state == IDLE && bus.requClutCacheUpdate) adrReg <= bus.adrClutCacheUpdate;
        end
    end

    // next state; an invalidate arriving with the last beat still forces a refetch
    always_comb begin
        nextState   = state;
        nextRestart = restart | (bus.i_invalidate && (state == REQ || state == RECV));
        cntClear    = 1'b0;
        case (state)
            IDLE: if (bus.requClutCacheUpdate) nextState = REQ;
            REQ: if (bus.i_memAck) begin
                nextState = RECV;
                cntClear  = 1'b1;
            end
            RECV: if (beat && cntLast) begin
                nextState   = nextRestart ? REQ : TAG;
                nextRestart = 1'b0;
            end
            TAG:     nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    assign bus.o_busy                  = state != IDLE;
    assign bus.o_memReq                = state == REQ;
    assign bus.o_memAdr                = adrReg;
    assign bus.o_clutWrite             = beat;
    assign bus.o_clutWrSlot            = adrReg[SLOT_BITS-1:0];
    assign bus.o_clutWrBeat            = cnt;
    assign bus.o_clutWrData            = bus.i_memData;
    assign bus.o_tagWrite              = state == TAG;
    assign bus.o_tagValue              = adrReg[CLUT_ADR_W-1:SLOT_BITS];
    assign bus.o_tagValid              = state == TAG;
    assign bus.updateClutCacheComplete = state == DONE;

endmodule

// File: tb/tb_clut_cache_filler.sv
// tb_clut_cache_filler: directed and randomized CLUT$ fills checked against a line-level reference model
module tb_clut_cache_filler;

    localparam int SLOT_BITS = 4;
    localparam int DATA_W    = 32;
    localparam int BEATS     = 8;

    logic clk = 1'b0;
    logic i_nrst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    clut_cache_filler_if #(.SLOT_BITS(SLOT_BITS), .DATA_W(DATA_W)) bus ();

    clut_cache_filler #(.SLOT_BITS(SLOT_BITS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .i_nrst(i_nrst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] sentData[$];
    logic [DATA_W-1:0] gotData[$];
    int                gotBeat[$];
    int                gotSlot[$];
    int                tagCount, doneCount, doneCyc, startCyc;
    logic [10:0]       lastTag;
    logic              lastTagValid;

    // observes cache-side strobes mid-cycle
    always @(negedge clk) begin
        if (bus.o_clutWrite) begin
            gotData.push_back(bus.o_clutWrData);
            gotBeat.push_back(int'(bus.o_clutWrBeat));
            gotSlot.push_back(int'(bus.o_clutWrSlot));
        end
        if (bus.o_tagWrite) begin
            tagCount++;
            lastTag      = bus.o_tagValue;
            lastTagValid = bus.o_tagValid;
        end
        if (bus.updateClutCacheComplete) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        sentData.delete();
        gotData.delete();
        gotBeat.delete();
        gotSlot.delete();
        tagCount     = 0;
        doneCount    = 0;
        doneCyc      = -1;
        lastTag      = '0;
        lastTagValid = 1'b0;
    endtask

    // arbiter model: waits for the request, acks after a delay, then returns one line of beats
    task automatic serve(input logic [14:0] expAdr, input int ackDelay, input int gap,
                         input int invBeat, input int stopBeat, input bit chgAdr, input bit fixedData);
        bit steady = 1'b1;
        int i = 0;
        step();
        while (!bus.o_memReq && i < 100) begin
            step();
            i++;
        end
        chk("memReq_seen", bus.o_memReq, 1);
        chk("memAdr", bus.o_memAdr, expAdr);
        repeat (ackDelay) begin
            step();
            if (bus.o_memReq !== 1'b1 || bus.o_memAdr !== expAdr) steady = 1'b0;
        end
        if (ackDelay > 0) chk("memReq_steady", steady, 1);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck = 1'b0;
        if (chgAdr) bus.adrClutCacheUpdate = expAdr ^ 15'h7FFF;
        for (int b = 0; b < BEATS; b++) begin
            if (b == stopBeat) return;
            repeat (gap) step();
            bus.i_memDataValid = 1'b1;
            bus.i_memData      = fixedData ? {16'(2*b+1), 16'(2*b)} : $urandom;
            bus.i_invalidate   = (b == invBeat);
            sentData.push_back(bus.i_memData);
            step();
            bus.i_memDataValid = 1'b0;
            bus.i_invalidate   = 1'b0;
        end
    endtask

    task automatic waitDone();
        int i = 0;
        while (!bus.updateClutCacheComplete && i < 200) begin
            step();
            i++;
        end
        chk("complete_seen", bus.updateClutCacheComplete, 1);
    endtask

    // reference: every beat of every pass lands in slot adr%16 at beat k%BEATS, one tag adr/16, one pulse
    task automatic checkFill(input logic [14:0] adr, input int nWrites);
        chk("write_count", gotData.size(), nWrites);
        for (int k = 0; k < nWrites && k < gotData.size(); k++) begin
            chk("wr_beat", gotBeat[k], k % BEATS);
            chk("wr_slot", gotSlot[k], adr % 16);
            chk("wr_data", gotData[k], sentData[k]);
        end
        chk("tag_count", tagCount, 1);
        chk("tag_value", lastTag, adr / 16);
        chk("tag_valid", lastTagValid, 1);
        chk("done_count", doneCount, 1);
        chk("busy_after", bus.o_busy, 0);
    endtask

    task automatic fill(input logic [14:0] adr, input int ackDelay, input int gap,
                        input int invBeat, input bit chgAdr, input bit fixedData);
        clearLogs();
        startCyc = cyc;
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = adr;
        serve(adr, ackDelay, gap, invBeat, -1, chgAdr, fixedData);
        if (invBeat >= 0) begin
            chk("restart_req", bus.o_memReq, 1);
            serve(adr, ackDelay, gap, -1, -1, 1'b0, 1'b0);
        end
        waitDone();
        bus.requClutCacheUpdate = 1'b0;
        repeat (3) step();
        checkFill(adr, invBeat >= 0 ? 2 * BEATS : BEATS);
    endtask

    initial begin
        logic [14:0] a;
        i_nrst                  = 1'b0;
        bus.requClutCacheUpdate = 1'b0;
        bus.adrClutCacheUpdate  = '0;
        bus.i_invalidate        = 1'b0;
        bus.i_memAck            = 1'b0;
        bus.i_memDataValid      = 1'b0;
        bus.i_memData           = '0;
        clearLogs();
        repeat (3) step();
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_memReq", bus.o_memReq, 0);
        chk("rst_memAdr", bus.o_memAdr, 0);
        chk("rst_clutWrite", bus.o_clutWrite, 0);
        chk("rst_wrBeat", bus.o_clutWrBeat, 0);
        chk("rst_tagWrite", bus.o_tagWrite, 0);
        chk("rst_tagValue", bus.o_tagValue, 0);
        chk("rst_tagValid", bus.o_tagValid, 0);
        chk("rst_complete", bus.updateClutCacheComplete, 0);
        i_nrst = 1'b1;
        step();

        // zero-wait fill with the reference pattern and latency check
        fill(15'h1A43, 0, 0, -1, 1'b0, 1'b1);
        chk("latency", doneCyc, startCyc + 3 + BEATS);
        chk("pattern_beat0", gotData.size() > 0 ? gotData[0] : '0, 32'h0001_0000);

        // arbiter stall with gapped beats
        fill(15'h1A43, 5, 2, -1, 1'b0, 1'b0);

        // invalidate mid-fill forces a full refetch
        fill(15'h1A43, 0, 0, 4, 1'b0, 1'b0);

        // invalidate in TAG does not refetch
        clearLogs();
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = 15'h0777;
        serve(15'h0777, 0, 0, -1, -1, 1'b0, 1'b0);
        bus.i_invalidate = bus.o_tagWrite;
        step();
        bus.i_invalidate = 1'b0;
        waitDone();
        bus.requClutCacheUpdate = 1'b0;
        repeat (3) step();
        checkFill(15'h0777, BEATS);

        // reset mid-fill, then stray beats, then a clean restart
        clearLogs();
        a = 15'($urandom);
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = a;
        serve(a, 0, 0, -1, 2, 1'b0, 1'b0);
        i_nrst = 1'b0;
        bus.requClutCacheUpdate = 1'b0;
        step();
        chk("midrst_busy", bus.o_busy, 0);
        chk("midrst_memReq", bus.o_memReq, 0);
        chk("midrst_memAdr", bus.o_memAdr, 0);
        i_nrst = 1'b1;
        repeat (6) begin
            bus.i_memDataValid = 1'b1;
            bus.i_memData      = $urandom;
            step();
        end
        bus.i_memDataValid = 1'b0;
        repeat (2) step();
        chk("midrst_writes", gotData.size(), 2);
        chk("midrst_tag", tagCount, 0);
        chk("midrst_done", doneCount, 0);
        fill(15'($urandom), 1, 0, -1, 1'b0, 1'b0);

        // request held one cycle past completion starts a second fill
        clearLogs();
        a = 15'($urandom);
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = a;
        serve(a, 0, 0, -1, -1, 1'b0, 1'b0);
        waitDone();
        bus.adrClutCacheUpdate = 15'h0005;
        step();
        checkFill(a, BEATS);
        clearLogs();
        step();
        bus.requClutCacheUpdate = 1'b0;
        serve(15'h0005, 0, 0, -1, -1, 1'b0, 1'b0);
        waitDone();
        repeat (3) step();
        checkFill(15'h0005, BEATS);

        // address change while busy is ignored
        fill(15'h2B6C, 2, 1, -1, 1'b1, 1'b0);

        // randomized fills
        for (int r = 0; r < 6; r++)
            fill(15'($urandom), $urandom_range(0, 4), $urandom_range(0, 2),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, BEATS - 1) : -1,
                 1'($urandom_range(0, 1)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
